// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-cycle wide add/sub sequencer driving a shared 16-bit adder slice
module wide_add_seq #(
  parameter int W   = 64,
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           op_sub,
  input  logic           op_cin,
  output logic [SEG-1:0] add_a,
  output logic [SEG-1:0] add_b,
  output logic           add_in,
  input  logic [SEG-1:0] add_sum,
  input  logic           add_coin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   res_sum,
  output logic           res_cout,
  output logic           res_ovf
);

  localparam int N  = W / SEG;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [BW-1:0]  beat;
  logic           carry;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           ovf_q;
  logic [SEG-1:0] seg_a;
  logic [SEG-1:0] seg_b;
  logic           last;

  assign last      = (beat == BW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_ovf   = ovf_q;

  // Select the current segment of each operand (B already inverted for subtract)
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < N; i++) begin
      if (beat == BW'(i)) begin
        seg_a = a_q[i*SEG +: SEG];
        seg_b = b_q[i*SEG +: SEG];
      end
    end
  end

  // Keep the shared adder inputs quiet whenever no segment is being issued
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_in = 1'b0;
    if (state == RUN) begin
      add_a  = seg_a;
      add_b  = seg_b;
      add_in = carry;
    end
  end

  // Control FSM, operand latch, carry chain and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_sub ? ~op_b : op_b;
            carry <= op_sub | op_cin;
            beat  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (beat == BW'(i)) sum_q[i*SEG +: SEG] <= add_sum;
          end
          carry <= add_coin;
          if (last) begin
            cout_q <= add_coin;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_sum[SEG-1] != a_q[W-1]);
            state  <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - scoreboard bench for wide_add_seq with a behavioural 16-bit adder slice
module tb_wide_add_seq;

  localparam int W = 64;
  localparam int SEG = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_sub;
  logic           op_cin;
  logic [SEG-1:0] add_a;
  logic [SEG-1:0] add_b;
  logic           add_in;
  logic [SEG-1:0] add_sum;
  logic           add_coin;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   res_sum;
  logic           res_cout;
  logic           res_ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  res_t sb[$];

  wide_add_seq #(.W(W), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_in(add_in),
    .add_sum(add_sum), .add_coin(add_coin),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf)
  );

  // external shared adder slice
  assign {add_coin, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SEG{1'b0}}, add_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out got none expected event", name);
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   t;
    res_t r;
    bb = sub ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum = t[W-1:0];
    r.cout = t[W];
    r.ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic o);
    res_t r;
    r.sum = s;
    r.cout = c;
    r.ovf = o;
    return r;
  endfunction

  // monitor: pops one expectation per output handshake
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got sum %h expected no output", res_sum);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("res_sum", {1'b0, res_sum}, {1'b0, e.sum});
        chk("res_cout", {{W{1'b0}}, res_cout}, {{W{1'b0}}, e.cout});
        chk("res_ovf", {{W{1'b0}}, res_ovf}, {{W{1'b0}}, e.ovf});
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin, output int acc);
    int  n;
    logic r;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    op_cin = cin;
    n = 0;
    acc = -1;
    while (acc < 0) begin
      r = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (r) acc = cyc;
      else if (++n > 60) begin
        timeout("accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int t);
    int n;
    n = 0;
    t = -1;
    while (!out_valid) begin
      @(negedge clk);
      if (++n > 60) begin
        timeout("out_valid");
        break;
      end
    end
    if (out_valid) t = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int prev;
    int t;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    logic rc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    op_sub = 1'b0;
    op_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", {{W{1'b0}}, in_ready}, 65'd1);
    chk("rst_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
    chk("rst_res_sum", {1'b0, res_sum}, 65'd0);
    chk("rst_add_a", {{(W-SEG+1){1'b0}}, add_a}, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: carry ripples through all segments
    sb.push_back(mk(64'h0, 1'b1, 1'b0));
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, acc);
    wait_out(t);
    chk("latency", 65'(t - acc), 65'd4);
    drain();

    // 2: subtract with borrow, carry-in forced on beat 0
    sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
    send(64'h0, 64'h1, 1'b1, 1'b0, acc);
    chk("beat0_add_in", {{W{1'b0}}, add_in}, 65'd1);
    chk("beat0_add_a", {{(W-SEG+1){1'b0}}, add_a}, 65'd0);
    chk("beat0_add_b", {{(W-SEG+1){1'b0}}, add_b}, 65'h0FFFE);
    drain();

    // 3: signed overflow
    sb.push_back(mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, acc);
    drain();

    // 4: back-pressure holds the result; new requests are ignored
    out_ready = 1'b0;
    sb.push_back(mk(64'd3, 1'b0, 1'b0));
    send(64'd1, 64'd2, 1'b0, 1'b0, acc);
    wait_out(t);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op_a = 64'(i * 100);
      op_b = 64'd5;
      @(posedge clk);
      @(negedge clk);
      chk("stall_sum", {1'b0, res_sum}, 65'd3);
      chk("stall_in_ready", {{W{1'b0}}, in_ready}, 65'd0);
      chk("stall_out_valid", {{W{1'b0}}, out_valid}, 65'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    sb.push_back(mk(64'd30, 1'b0, 1'b0));
    send(64'd10, 64'd20, 1'b0, 1'b0, acc);
    drain();

    // 5: reset in the middle of an operation
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("beat2_add_a", {{(W-SEG+1){1'b0}}, add_a}, 65'h05678);
    rst_n = 1'b0;
    #1;
    chk("abort_res_sum", {1'b0, res_sum}, 65'd0);
    chk("abort_res_cout", {{W{1'b0}}, res_cout}, 65'd0);
    chk("abort_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
    chk("abort_in_ready", {{W{1'b0}}, in_ready}, 65'd1);
    chk("abort_add_a", {{(W-SEG+1){1'b0}}, add_a}, 65'd0);
    chk("abort_add_in", {{W{1'b0}}, add_in}, 65'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(mk(64'd12, 1'b0, 1'b0));
    send(64'd5, 64'd7, 1'b0, 1'b0, acc);
    drain();

    // 6: back-to-back mixed operations against the reference model
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      sb.push_back(model(ra, rb, rs, rc));
      send(ra, rb, rs, rc, acc);
      if (i > 0) chk("op_period", 65'(acc - prev), 65'd6);
      prev = acc;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
